muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULTU/DIVU that reuses the shared ALU instead of a dedicated multiplier or divider.
- Runs a 32-iteration unsigned shift-add multiply or restoring divide, driving the ALU's a/b/aluop each cycle and reading back out.
- Results land in internal HI/LO registers.
- Sits beside the execute stage. The execute-stage ALU input mux selects this block's alu_* outputs while alu_own is high.

Parameters:
- WORD_W, 32, operand/result width. Only 32 is supported. Iteration counter is 5 bits and counts 0..31.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled in IDLE and DONE only
- op  in  1  0 = MULTU, 1 = DIVU; latched with start
- rs  in  32  multiplicand / dividend; latched with start
- rt  in  32  multiplier / divisor; latched with start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; results valid
- hi  out  32  HI register (product[63:32] / remainder)
- lo  out  32  LO register (product[31:0] / quotient)
- alu_own  out  1  equals busy; ALU mux select
- alu_a  out  32  ALU a operand
- alu_b  out  32  ALU b operand
- alu_op  out  4  aluop_t code: ALU_ADD or ALU_SUB
- alu_out  in  32  ALU result, combinational, same cycle

Behaviour:
- Clock and reset: one clock CLK. Synchronous active-high reset RST.
- State on reset: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0, count = 0.
- Registers: op_r and opnd (latched rt).
- Idle ALU drive: when not RUN, alu_a = alu_b = 0 and alu_op = ALU_ADD.
- Reset mid-operation: RST in any state, including RUN, aborts immediately to the reset values. A partial result is never exposed.
- FSM:
  - IDLE: on start → RUN. Load op_r = op, opnd = rt, count = 0. For MULTU, hi = 0 and lo = rs. For DIVU, hi = 0 and lo = rs.
  - RUN: one iteration per cycle. When count == 31 → DONE, else count++. start is ignored.
  - DONE: done = 1 for this cycle only. If start → RUN (same load as IDLE, back-to-back), else → IDLE.
- Latency: start sampled at edge 0 gives RUN for cycles 1..32, done = 1 in cycle 33. hi/lo hold from DONE until the next accepted start.
- MULTU iteration (alu_op = ALU_ADD, alu_a = hi, alu_b = opnd):
  - If lo[0] = 1: c = (hi[31] & opnd[31]) | ((hi[31] | opnd[31]) & ~alu_out[31]), which is the carry-out rebuilt from the 32-bit ALU. Then hi ← {c, alu_out[31:1]} and lo ← {alu_out[0], lo[31:1]}.
  - If lo[0] = 0: hi ← {1'b0, hi[31:1]} and lo ← {hi[0], lo[31:1]}. The ALU result is ignored.
- DIVU iteration (alu_op = ALU_SUB, alu_a = r_sh = {hi[30:0], lo[31]}, alu_b = opnd; m = hi[31]):
  - borrow = (~r_sh[31] & opnd[31]) | (~(r_sh[31] ^ opnd[31]) & alu_out[31]).
  - If m | ~borrow: hi ← alu_out and lo ← {lo[30:0], 1}.
  - Else: hi ← r_sh and lo ← {lo[30:0], 0}.
- ALU flags: the ALU's overflow/negative/zero outputs are not used.
- Divide by zero: no special case. The algorithm naturally yields lo = 0xFFFFFFFF and hi = rs, and this behaviour is required.
- Ownership: alu_own is 1 exactly while in RUN. The execute stage must stall while busy, and its mfhi/mflo must wait for done.

Test Plan:
- Reset, then MULTU rs = 3, rt = 5 → busy for cycles 1..32, done in cycle 33, hi = 0x00000000, lo = 0x0000000F.
- MULTU rs = rt = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001 (exercises the carry reconstruction).
- DIVU 100 / 7 → lo = 14, hi = 2. DIVU 0xFFFFFFFF / 0x80000001 → lo = 1, hi = 0x7FFFFFFE (exercises the m = 1 path).
- DIVU 5 / 0 → lo = 0xFFFFFFFF, hi = 5, done in cycle 33.
- start pulsed during RUN with different operands → ignored, and the original result is returned. start asserted in the DONE cycle → a new op runs with no IDLE gap, and done follows 33 cycles later.
- RST asserted in cycle 10 of RUN → next cycle busy = 0, done = 0, hi = lo = 0, alu_own = 0. No done pulse follows.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the execute-stage ALU:
// 32 shift-add (multiply) or restoring-subtract (divide) steps into HI/LO.
module muldiv_seq #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              op,
    input  logic [WORD_W-1:0] rs,
    input  logic [WORD_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo,
    output logic              alu_own,
    output logic [WORD_W-1:0] alu_a,
    output logic [WORD_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [WORD_W-1:0] alu_out
);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [4:0]        count_q;
    logic              op_q;
    logic [WORD_W-1:0] opnd_q;
    logic [WORD_W-1:0] hi_q, lo_q;
    logic [WORD_W-1:0] hi_d, lo_d;
    logic [WORD_W-1:0] r_sh;
    logic              carry, borrow;

    // The ALU is only 32 bits wide, so carry/borrow are rebuilt from the sign bits.
    assign r_sh   = {hi_q[WORD_W-2:0], lo_q[WORD_W-1]};
    assign carry  = (hi_q[WORD_W-1] & opnd_q[WORD_W-1]) |
                    ((hi_q[WORD_W-1] | opnd_q[WORD_W-1]) & ~alu_out[WORD_W-1]);
    assign borrow = (~r_sh[WORD_W-1] & opnd_q[WORD_W-1]) |
                    (~(r_sh[WORD_W-1] ^ opnd_q[WORD_W-1]) & alu_out[WORD_W-1]);

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        if (state_q == S_RUN) begin
            alu_b = opnd_q;
            if (op_q) begin
                alu_a  = r_sh;
                alu_op = ALU_SUB;
            end else begin
                alu_a  = hi_q;
            end
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (op_q) begin
            // hi[31] set means the 33-bit partial remainder always exceeds the divisor.
            if (hi_q[WORD_W-1] | ~borrow) begin
                hi_d = alu_out;
                lo_d = {lo_q[WORD_W-2:0], 1'b1};
            end else begin
                hi_d = r_sh;
                lo_d = {lo_q[WORD_W-2:0], 1'b0};
            end
        end else if (lo_q[0]) begin
            hi_d = {carry, alu_out[WORD_W-1:1]};
            lo_d = {alu_out[0], lo_q[WORD_W-1:1]};
        end else begin
            hi_d = {1'b0, hi_q[WORD_W-1:1]};
            lo_d = {hi_q[0], lo_q[WORD_W-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    if (count_q == 5'd31) begin
                        state_q <= S_DONE;
                    end else begin
                        count_q <= count_q + 5'd1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= S_RUN;
                        op_q    <= op;
                        opnd_q  <= rt;
                        count_q <= '0;
                        hi_q    <= '0;
                        lo_q    <= rs;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign alu_own = busy;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a behavioural ALU beside the DUT, directed vectors,
// corner sequences and random operations checked against plain 64-bit arithmetic.
module tb_muldiv_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        op;
    logic [31:0] rs, rt;
    logic        busy, done, alu_own;
    logic [31:0] hi, lo, alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;

    int nvec = 0;
    int nfail = 0;

    muldiv_seq #(.WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .rs(rs), .rt(rt),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_own(alu_own),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

    always #5 CLK = ~CLK;

    // Shared ALU: code 1 subtracts, code 0 adds.
    assign alu_out = (alu_op == 4'd1) ? (alu_a - alu_b) : (alu_a + alu_b);

    typedef struct {
        logic        op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!o) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else begin
            p = {a % b, a / b};
        end
        return p;
    endfunction

    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
    endtask

    // Call with start already raised; returns sampled in the done cycle (or at timeout).
    task automatic wait_done(input int pulse_at, output int lat, output int bcnt, output int own_bad);
        int cyc;
        @(posedge CLK); #1;
        start   = 1'b0;
        cyc     = 1;
        bcnt    = 0;
        own_bad = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            if (alu_own !== busy) own_bad++;
            if (cyc == pulse_at) begin
                start = 1'b1;
                op    = ~op;
                rs    = $urandom;
                rt    = $urandom;
            end else if (cyc == pulse_at + 1) begin
                start = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        lat = cyc;
    endtask

    vec_t tbl[6];
    int lat, bcnt, own_bad, dcnt;
    logic [63:0] exp_r;
    logic [31:0] ra, rb;
    logic ro;

    initial begin
        tbl[0] = '{1'b0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{1'b1, 32'd100,        32'd7,          32'd2,         32'd14};
        tbl[3] = '{1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE, 32'h0000_0001};
        tbl[4] = '{1'b1, 32'd5,          32'd0,          32'd5,         32'hFFFF_FFFF};
        tbl[5] = '{1'b0, 32'h8000_0000,  32'h8000_0001,  32'h4000_0000, 32'h8000_0000};

        RST = 1'b1; start = 1'b0; op = 1'b0; rs = '0; rt = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_own",  {63'd0, alu_own}, 64'd0);
        chk("idle_alu",   {alu_a, alu_b}, 64'd0);
        chk("idle_aluop", {60'd0, alu_op}, 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].op, tbl[i].rs, tbl[i].rt);
            wait_done(0, lat, bcnt, own_bad);
            chk($sformatf("vec%0d_latency", i), lat, 33);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32);
            chk($sformatf("vec%0d_own", i), own_bad, 0);
            chk($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, tbl[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, tbl[i].lo});
            @(posedge CLK); #1;
        end

        // hi/lo must hold while idle after done
        repeat (3) @(posedge CLK);
        #1;
        chk("hold_hilo", {hi, lo}, {tbl[5].hi, tbl[5].lo});
        chk("hold_idle", {62'd0, busy, done}, 64'd0);

        // start pulsed in RUN is ignored
        issue(1'b0, 32'd123456, 32'd789);
        wait_done(5, lat, bcnt, own_bad);
        chk("ignore_latency", lat, 33);
        chk("ignore_result", {hi, lo}, model(1'b0, 32'd123456, 32'd789));

        // back-to-back: start raised in the DONE cycle
        issue(1'b1, 32'hDEAD_BEEF, 32'd1000);
        wait_done(0, lat, bcnt, own_bad);
        chk("b2b_first_result", {hi, lo}, model(1'b1, 32'hDEAD_BEEF, 32'd1000));
        issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(0, lat, bcnt, own_bad);
        chk("b2b_latency", lat, 33);
        chk("b2b_busy_cycles", bcnt, 32);
        chk("b2b_result", {hi, lo}, model(1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
        @(posedge CLK); #1;

        // reset in cycle 10 of RUN
        issue(1'b0, 32'hFFFF_FFFF, 32'hF0F0_F0F0);
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_own",  {63'd0, alu_own}, 64'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (done || busy) dcnt++;
        end
        chk("midrst_no_done", dcnt, 0);

        // random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom_range(0, 15);
                1:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            exp_r = model(ro, ra, rb);
            issue(ro, ra, rb);
            wait_done(0, lat, bcnt, own_bad);
            chk($sformatf("rand%0d op=%0d rs=%h rt=%h latency", i, ro, ra, rb), lat, 33);
            chk($sformatf("rand%0d op=%0d rs=%h rt=%h result", i, ro, ra, rb), {hi, lo}, exp_r);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
